// File: rtl/seq3_match_monitor_pkg.sv
// Shared types and helpers for the three-step sequence monitor (seq_mon_pkg).
package seq_mon_pkg;

  // Stage vector packed as {s2, s1}
  typedef logic [1:0] seq_stage_t;

  localparam int STAGES = 3;

  // Saturating increment for counters up to 32 bits wide
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] lim;
    lim = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= lim) ? lim : value + 32'd1;
  endfunction

endpackage

// File: rtl/seq3_match_monitor_if.sv
// Observed value stream: valid qualifies data; the monitor has no ready and samples every cycle.
interface seq3_match_monitor_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data);
  modport slave  (input valid, input data);
endinterface

// File: rtl/seq3_match_monitor_sat.sv
// Saturating up-counter with synchronous clear, used for the hit count and cycle timestamp.
module seq_mon_sat_counter
  import seq_mon_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= CNT_W'(sat_inc(32'(r_q), CNT_W));
    end
  end

  assign q = r_q;

endmodule

// File: rtl/seq3_match_monitor.sv
// Run-time checker for PAT0 ##1 PAT1 ##1 PAT2 on a qualified value stream.
// Optional SEQ_MON_TIMESTAMP_EN records the cycle index of the first completion.
module seq3_match_monitor
  import seq_mon_pkg::*;
#(
  parameter int              WIDTH = 32,
  parameter logic [WIDTH-1:0] PAT0 = WIDTH'(3),
  parameter logic [WIDTH-1:0] PAT1 = WIDTH'(4),
  parameter logic [WIDTH-1:0] PAT2 = WIDTH'(5),
  parameter int              CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  seq3_match_monitor_if.slave  bus,
  output logic                 match,
  output logic                 covered,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     first_hit_cycle,
  output seq_stage_t           dbg_stage
);

  seq_stage_t r_stage;
  seq_stage_t w_stage_n;
  logic       w_hit;
  logic       r_match;
  logic       r_covered;

  // Each stage bit is one live attempt; a new attempt may begin every cycle.
  always_comb begin
    w_stage_n = '0;
    w_hit     = 1'b0;
    if (bus.valid) begin
      w_stage_n[0] = (bus.data == PAT0);
      w_stage_n[1] = r_stage[0] && (bus.data == PAT1);
      w_hit        = r_stage[1] && (bus.data == PAT2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage   <= '0;
      r_match   <= 1'b0;
      r_covered <= 1'b0;
    end else begin
      r_stage   <= w_stage_n;
      r_match   <= w_hit;
      r_covered <= r_covered | w_hit;
    end
  end

  seq_mon_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .en  (w_hit),
    .clr (1'b0),
    .q   (hit_count)
  );

`ifdef SEQ_MON_TIMESTAMP_EN
  logic [CNT_W-1:0] w_cycle;
  logic [CNT_W-1:0] r_first;

  seq_mon_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (1'b0),
    .q   (w_cycle)
  );

  // Only the first completion since reset is recorded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first <= '0;
    end else if (w_hit && !r_covered) begin
      r_first <= w_cycle;
    end
  end

  assign first_hit_cycle = r_first;
`else
  assign first_hit_cycle = '0;
`endif

  assign match     = r_match;
  assign covered   = r_covered;
  assign dbg_stage = r_stage;

endmodule

// File: tb/tb_seq3_match_monitor.sv
// Randomized and directed bench for seq3_match_monitor; four parameterisations share one stream.
module tb_seq3_match_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_valid;
  logic [31:0] tb_data;

  always #5 clk = ~clk;

  seq3_match_monitor_if #(.WIDTH(32)) if_a ();
  seq3_match_monitor_if #(.WIDTH(32)) if_b ();
  seq3_match_monitor_if #(.WIDTH(32)) if_c ();
  seq3_match_monitor_if #(.WIDTH(32)) if_d ();

  assign if_a.valid = tb_valid;
  assign if_a.data  = tb_data;
  assign if_b.valid = tb_valid;
  assign if_b.data  = tb_data;
  assign if_c.valid = tb_valid;
  assign if_c.data  = tb_data;
  assign if_d.valid = tb_valid;
  assign if_d.data  = tb_data;

  logic        match_a, match_b, match_c, match_d;
  logic        cov_a, cov_b, cov_c, cov_d;
  logic [15:0] cnt_a, cnt_b, cnt_c, ts_a, ts_b, ts_c;
  logic [1:0]  cnt_d, ts_d;
  logic [1:0]  stg_a, stg_b, stg_c, stg_d;

  seq3_match_monitor dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .match(match_a), .covered(cov_a),
    .hit_count(cnt_a), .first_hit_cycle(ts_a), .dbg_stage(stg_a)
  );

  seq3_match_monitor #(.PAT0(32'd2), .PAT1(32'd3), .PAT2(32'd100)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .match(match_b), .covered(cov_b),
    .hit_count(cnt_b), .first_hit_cycle(ts_b), .dbg_stage(stg_b)
  );

  seq3_match_monitor #(.PAT0(32'd7), .PAT1(32'd7), .PAT2(32'd7)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c), .match(match_c), .covered(cov_c),
    .hit_count(cnt_c), .first_hit_cycle(ts_c), .dbg_stage(stg_c)
  );

  seq3_match_monitor #(.CNT_W(2)) dut_d (
    .clk(clk), .rst(rst), .bus(if_d), .match(match_d), .covered(cov_d),
    .hit_count(cnt_d), .first_hit_cycle(ts_d), .dbg_stage(stg_d)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: last three samples since reset, judged directly against the pattern
  int unsigned pat [4][3];
  int unsigned maxv[4];
  bit          hv[$];
  logic [31:0] hd[$];
  int unsigned cyc;
  bit          e_cov  [4];
  int unsigned e_cnt  [4];
  int unsigned e_first[4];
  logic [0:0]  exp_q[$];

  function automatic bit tail_match(input int k, input int n);
    int sz;
    sz = hv.size();
    if (sz < n) return 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!hv[sz-n+i] || hd[sz-n+i] != pat[k][i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    hv.delete();
    hd.delete();
    exp_q.delete();
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      e_cov[k]   = 1'b0;
      e_cnt[k]   = 0;
      e_first[k] = 0;
    end
  endtask

  task automatic model_step(input bit v, input logic [31:0] d);
    hv.push_back(v);
    hd.push_back(d);
    if (hv.size() > 3) begin
      void'(hv.pop_front());
      void'(hd.pop_front());
    end
    for (int k = 0; k < 4; k++) begin
      if (tail_match(k, 3)) begin
        if (e_cnt[k] < maxv[k]) e_cnt[k]++;
        if (!e_cov[k]) begin
          e_first[k] = (cyc > maxv[k]) ? maxv[k] : cyc;
          e_cov[k]   = 1'b1;
        end
      end
    end
    exp_q.push_back(tail_match(0, 3));
    cyc++;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] m, c, n, t, s, et;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       begin m = 32'(match_a); c = 32'(cov_a); n = 32'(cnt_a); t = 32'(ts_a); s = 32'(stg_a); end
        1:       begin m = 32'(match_b); c = 32'(cov_b); n = 32'(cnt_b); t = 32'(ts_b); s = 32'(stg_b); end
        2:       begin m = 32'(match_c); c = 32'(cov_c); n = 32'(cnt_c); t = 32'(ts_c); s = 32'(stg_c); end
        default: begin m = 32'(match_d); c = 32'(cov_d); n = 32'(cnt_d); t = 32'(ts_d); s = 32'(stg_d); end
      endcase
`ifdef SEQ_MON_TIMESTAMP_EN
      et = e_first[k];
`else
      et = 0;
`endif
      check_val($sformatf("%s/d%0d/match", tag, k), m, 32'(tail_match(k, 3)));
      check_val($sformatf("%s/d%0d/covered", tag, k), c, 32'(e_cov[k]));
      check_val($sformatf("%s/d%0d/hit_count", tag, k), n, e_cnt[k]);
      check_val($sformatf("%s/d%0d/first_hit", tag, k), t, et);
      check_val($sformatf("%s/d%0d/stage", tag, k), s,
                {30'd0, tail_match(k, 2), tail_match(k, 1)});
    end
    if (exp_q.size() > 0) check_val($sformatf("%s/sb_match", tag), 32'(match_a), 32'(exp_q.pop_front()));
  endtask

  task automatic step(input bit v, input logic [31:0] d);
    tb_valid = v;
    tb_data  = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    check_all("step");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_ts;
    rst      = 1'b1;
    tb_valid = 1'b0;
    tb_data  = '0;
    pat[0] = '{3, 4, 5};   maxv[0] = 16'hFFFF;
    pat[1] = '{2, 3, 100}; maxv[1] = 16'hFFFF;
    pat[2] = '{7, 7, 7};   maxv[2] = 16'hFFFF;
    pat[3] = '{3, 4, 5};   maxv[3] = 3;

    // Free-running counter
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 32'(i));
`ifdef SEQ_MON_TIMESTAMP_EN
    exp_ts = 5;
`else
    exp_ts = 0;
`endif
    check_val("t1_covered", 32'(cov_a), 1);
    check_val("t1_count", 32'(cnt_a), 1);
    check_val("t1_first", 32'(ts_a), exp_ts);

    // Pattern that never completes on 0..99
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, 32'(i));
    check_val("t2_count", 32'(cnt_b), 0);
    check_val("t2_covered", 32'(cov_b), 0);

    // valid gap breaks the attempt
    do_reset();
    step(1'b1, 3); step(1'b1, 4); step(1'b0, 0); step(1'b1, 5);
    check_val("t3_gap_count", 32'(cnt_a), 0);
    check_val("t3_gap_stage", 32'(stg_a), 0);
    step(1'b1, 3); step(1'b1, 4); step(1'b1, 5);
    check_val("t3_count", 32'(cnt_a), 1);

    // Overlapping hits on an all-equal pattern
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 7);
    check_val("t4_count", 32'(cnt_c), 2);
    check_val("t4_match", 32'(match_c), 1);

    // Saturation on the narrow counter
    do_reset();
    for (int b = 0; b < 5; b++) begin
      step(1'b1, 3); step(1'b1, 4); step(1'b1, 5); step(1'b1, 0);
    end
    check_val("t5_sat", 32'(cnt_d), 3);
    check_val("t5_covered", 32'(cov_d), 1);
    check_val("t5_wide", 32'(cnt_a), 5);

    // Reset mid-sequence
    do_reset();
    step(1'b1, 3); step(1'b1, 4);
    do_reset();
    step(1'b1, 5);
    check_val("t6_match", 32'(match_a), 0);
    check_val("t6_count", 32'(cnt_a), 0);

    // Random stream
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      logic [31:0] d;
      if ($urandom_range(0, 199) == 0) do_reset();
      r = $urandom_range(0, 19);
      if (r == 0)      d = $urandom;
      else if (r == 1) d = 32'h0010_0003;
      else if (r == 2) d = 32'd100;
      else             d = 32'($urandom_range(2, 7));
      step($urandom_range(0, 9) != 0, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
